// File: rtl/field_reader_if.sv
// Request/response bus for field_reader: valid/ready request carrying a field
// position, length and tag, and a valid/ready response carrying the extracted field.
interface field_reader_if #(
    parameter int WIDTH = 16
);
    localparam int LSB_W = $clog2(WIDTH);

    logic             req_valid;
    logic             req_ready;
    logic [LSB_W-1:0] req_lsb;
    logic [LSB_W:0]   req_len;
    logic [3:0]       req_tag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic [3:0]       rsp_tag;
    logic             rsp_err;
    logic [7:0]       rsp_count;

    modport master (
        output req_valid, req_lsb, req_len, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_tag, rsp_err, rsp_count
    );

    modport slave (
        input  req_valid, req_lsb, req_len, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_tag, rsp_err, rsp_count
    );
endinterface

// File: rtl/field_reader.sv
// Pipelined right-aligned bit-field read of a WIDTH-bit source with tag return and
// output backpressure. Define FIELD_READER_SNAPSHOT_EN to read from a snap-loaded copy.
module field_reader #(
    parameter int WIDTH   = 16,
    parameter int LATENCY = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] src_word,
    input  logic             snap,
    field_reader_if.slave    bus
);
    localparam int LSB_W = $clog2(WIDTH);
    localparam int LEN_W = LSB_W + 1;

    logic [WIDTH-1:0] src;

`ifdef FIELD_READER_SNAPSHOT_EN
    logic [WIDTH-1:0] snap_q, snap_d;

    always_comb begin
        snap_d = snap ? src_word : snap_q;
    end

    always_ff @(posedge clock) begin
        if (reset) snap_q <= '0;
        else       snap_q <= snap_d;
    end

    // Acceptance reads the pre-edge snapshot, so a same-edge snap is not seen.
    assign src = snap_q;
`else
    logic snap_unused;
    assign snap_unused = snap;
    assign src         = src_word;
`endif

    logic             len_bad;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] field;

    // A shift by WIDTH yields zero, so len == WIDTH gives an all-ones mask.
    always_comb begin
        len_bad = (bus.req_len == '0) || (bus.req_len > LEN_W'(WIDTH));
        mask    = ~({WIDTH{1'b1}} << bus.req_len);
        field   = len_bad ? '0 : ((src >> bus.req_lsb) & mask);
    end

    logic [LATENCY-1:0]            vld_pipe_q, vld_pipe_d;
    logic [LATENCY-1:0][WIDTH-1:0] data_pipe_q, data_pipe_d;
    logic [LATENCY-1:0][3:0]       tag_pipe_q, tag_pipe_d;
    logic [LATENCY-1:0]            err_pipe_q, err_pipe_d;
    logic [7:0]                    rsp_count_q, rsp_count_d;
    logic                          stall;

    always_comb begin
        stall       = vld_pipe_q[LATENCY-1] && !bus.rsp_ready;
        vld_pipe_d  = vld_pipe_q;
        data_pipe_d = data_pipe_q;
        tag_pipe_d  = tag_pipe_q;
        err_pipe_d  = err_pipe_q;
        // Whole pipe moves in lockstep; bubbles travel with it.
        if (!stall) begin
            vld_pipe_d[0]  = bus.req_valid;
            data_pipe_d[0] = field;
            tag_pipe_d[0]  = bus.req_tag;
            err_pipe_d[0]  = len_bad;
            for (int i = 1; i < LATENCY; i++) begin
                vld_pipe_d[i]  = vld_pipe_q[i-1];
                data_pipe_d[i] = data_pipe_q[i-1];
                tag_pipe_d[i]  = tag_pipe_q[i-1];
                err_pipe_d[i]  = err_pipe_q[i-1];
            end
        end
        rsp_count_d = rsp_count_q + {7'd0, vld_pipe_q[LATENCY-1] && bus.rsp_ready};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_pipe_q  <= '0;
            data_pipe_q <= '0;
            tag_pipe_q  <= '0;
            err_pipe_q  <= '0;
            rsp_count_q <= '0;
        end else begin
            vld_pipe_q  <= vld_pipe_d;
            data_pipe_q <= data_pipe_d;
            tag_pipe_q  <= tag_pipe_d;
            err_pipe_q  <= err_pipe_d;
            rsp_count_q <= rsp_count_d;
        end
    end

    assign bus.req_ready = !stall;
    assign bus.rsp_valid = vld_pipe_q[LATENCY-1];
    assign bus.rsp_data  = data_pipe_q[LATENCY-1];
    assign bus.rsp_tag   = tag_pipe_q[LATENCY-1];
    assign bus.rsp_err   = err_pipe_q[LATENCY-1];
    assign bus.rsp_count = rsp_count_q;
endmodule

// File: tb/tb_field_reader.sv
// Scoreboard bench for field_reader: the driver queues bit-by-bit reference results at
// acceptance, and a negedge monitor checks data, tag, err, latency, req_ready and rsp_count.
module tb_field_reader;
    localparam int W = 16;
    localparam int L = 2;

    typedef struct {
        logic [W-1:0] data;
        logic [3:0]   tag;
        logic         err;
        int           g;
    } exp_t;

    logic         clock;
    logic         reset;
    logic [W-1:0] src_word;
    logic         snap;

    field_reader_if #(.WIDTH(W)) bus ();

    field_reader #(.WIDTH(W), .LATENCY(L)) dut (
        .clock    (clock),
        .reset    (reset),
        .src_word (src_word),
        .snap     (snap),
        .bus      (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    exp_t         sb[$];
    int           got_tags[$];
    int           errors = 0;
    int           checks = 0;
    int           adv_total = 0;
    int           model_count = 0;
    logic [W-1:0] model_snap = '0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endfunction

    // Walk the field one bit at a time; positions past the top read as zero.
    function automatic logic [W-1:0] ref_field(logic [W-1:0] src, int lsb, int len);
        logic [W-1:0] r;
        r = '0;
        if (len < 1 || len > W) return r;
        for (int i = 0; i < len; i++)
            if (lsb + i < W) r[i] = src[lsb+i];
        return r;
    endfunction

    task automatic step(output bit acc);
        exp_t         e;
        logic [W-1:0] s;
        @(negedge clock);
        acc = bus.req_valid && bus.req_ready && !reset;
`ifdef FIELD_READER_SNAPSHOT_EN
        s = model_snap;
`else
        s = src_word;
`endif
        if (acc) begin
            e.data = ref_field(s, int'(bus.req_lsb), int'(bus.req_len));
            e.err  = (bus.req_len == 0) || (int'(bus.req_len) > W);
            e.tag  = bus.req_tag;
            e.g    = adv_total;
            sb.push_back(e);
        end
        if (reset)     model_snap = '0;
        else if (snap) model_snap = src_word;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(int n);
        bit acc;
        for (int i = 0; i < n; i++) step(acc);
    endtask

    task automatic send(int lsb, int len, int tag);
        bit acc;
        int n;
        n = 0;
        bus.req_valid = 1'b1;
        bus.req_lsb   = 4'(lsb);
        bus.req_len   = 5'(len);
        bus.req_tag   = 4'(tag);
        do begin
            step(acc);
            n++;
        end while (!acc && n < 50);
        chk("send_accept", {31'd0, acc}, 32'd1);
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        while (sb.size() > 0 && n < 60) begin
            idle(1);
            n++;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    // Monitor: runs just after each negedge and judges the state the coming edge will see.
    initial begin
        bit   prev_reset;
        bit   stall;
        exp_t h;
        prev_reset = 1'b0;
        forever begin
            @(negedge clock);
            #1;
            stall = bus.rsp_valid && !bus.rsp_ready;
            chk("req_ready", {31'd0, bus.req_ready}, {31'd0, !stall});
            chk("rsp_count", {24'd0, bus.rsp_count}, {24'd0, 8'(model_count)});
            if (prev_reset) begin
                chk("reset_valid", {31'd0, bus.rsp_valid}, 32'd0);
                chk("reset_data", {16'd0, bus.rsp_data}, 32'd0);
                chk("reset_tag_err", {27'd0, bus.rsp_tag, bus.rsp_err}, 32'd0);
            end
            if (bus.rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", {31'd0, bus.rsp_valid}, 32'd0);
                end else begin
                    h = sb[0];
                    chk("rsp_data", {16'd0, bus.rsp_data}, {16'd0, h.data});
                    chk("rsp_tag", {28'd0, bus.rsp_tag}, {28'd0, h.tag});
                    chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, h.err});
                    chk("rsp_latency", adv_total - h.g, L);
                end
            end else if (sb.size() > 0 && adv_total - sb[0].g >= L) begin
                chk("missing_rsp", {31'd0, bus.rsp_valid}, 32'd1);
            end
            if (reset) begin
                sb.delete();
                model_count = 0;
            end else begin
                if (bus.rsp_valid && bus.rsp_ready && sb.size() > 0) begin
                    h = sb.pop_front();
                    got_tags.push_back(int'(h.tag));
                    model_count++;
                end
                if (!stall) adv_total++;
            end
            prev_reset = reset;
        end
    end

    initial begin
        bit acc;
        int t;
        int cyc;
        reset         = 1'b1;
        src_word      = 16'hA5C3;
        snap          = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_lsb   = '0;
        bus.req_len   = '0;
        bus.req_tag   = '0;
        bus.rsp_ready = 1'b1;
        idle(3);
        reset = 1'b0;

        // Basic and boundary extractions on 16'hA5C3
        send(4, 8, 3);
        idle(1);
        send(0, 16, 1);
        send(12, 8, 2);
        send(0, 0, 4);
        send(3, 17, 5);
        send(15, 1, 6);
        drain();

        // Backpressure: 6 back-to-back tags with a 3-cycle consumer stall
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        got_tags.delete();
        t   = 0;
        cyc = 0;
        while (t < 6 && cyc < 60) begin
            bus.rsp_ready = !(cyc >= 3 && cyc <= 5);
            bus.req_valid = 1'b1;
            bus.req_lsb   = 4'(t);
            bus.req_len   = 5'(4);
            bus.req_tag   = 4'(t);
            step(acc);
            if (acc) t++;
            cyc++;
        end
        drain();
        chk("bp_tag_count", got_tags.size(), 6);
        for (int i = 0; i < got_tags.size(); i++) chk("bp_tag_order", got_tags[i], i);
        chk("bp_rsp_count", {24'd0, bus.rsp_count}, 32'd6);

        // Source changes after acceptance must not affect the in-flight request
        src_word = 16'h00FF;
        send(0, 8, 7);
        src_word = 16'hFF00;
        drain();

        // Reset mid-flight discards both requests
        send(0, 8, 8);
        send(8, 8, 9);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("rst_mid_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_mid_count", {24'd0, bus.rsp_count}, 32'd0);
        chk("rst_mid_ready", {31'd0, bus.req_ready}, 32'd1);
        idle(3);

        // Snapshot capture, then same-edge snap and accept
        src_word = 16'h1234;
        snap     = 1'b1;
        idle(1);
        snap     = 1'b0;
        src_word = 16'hFFFF;
        send(0, 16, 10);
        src_word = 16'h5555;
        snap     = 1'b1;
        send(0, 16, 11);
        snap = 1'b0;
        send(0, 16, 12);
        drain();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            reset         = ($urandom_range(0, 99) == 0);
            bus.rsp_ready = ($urandom_range(0, 9) < 7);
            bus.req_valid = ($urandom_range(0, 3) != 0);
            bus.req_lsb   = 4'($urandom_range(0, W - 1));
            bus.req_len   = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, W + 1));
            bus.req_tag   = 4'($urandom);
            snap          = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 2) == 0) src_word = 16'($urandom);
            idle(1);
        end
        reset = 1'b0;
        snap  = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
